sr_omega_slewer: RTL and testbench

Rate-limits the per-harmonic OMEGA_DT targets produced by the SR frequency-drift stage before they reach the SR oscillator bank. Each harmonic's applied omega moves toward its target by at most MAX_STEP per slew period, so no oscillator sees a discontinuous frequency step. A small FSM scans the harmonics round-robin, one per clock, once per slew period, and reports settle and update status.

---
 rtl/sr_omega_slewer.sv | 226 ++++++++++++++++++++++
 tb/tb_sr_omega_slewer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_omega_slewer.sv
// ---------------------------------------------------------------------------
// sr_omega_slewer
//
// Rate-limits the per-harmonic OMEGA_DT targets from the SR frequency-drift
// stage before they reach the SR oscillator bank. Each harmonic's applied
// omega moves toward its target by at most MAX_STEP per slew period. A small
// FSM (INIT -> WAIT -> SCAN) visits the harmonics round-robin, one per clock,
// once per slew period.
//
// Optional feature macro: SR_SLEW_SNAP_EN
//   defined   : a harmonic whose distance to target exceeds SNAP_THRESH
//               jumps straight to the target in one scan.
//   undefined : every change is slew-limited; SNAP_THRESH has no effect.
//
// Ports
//   clk              in   system clock
//   rst_n            in   synchronous active-low reset
//   clk_en           in   4 kHz update enable, one clk wide
//   target_packed    in   signed targets, harmonic k at [k*WIDTH +: WIDTH]
//   hold             in   freezes the slew-period divider while high
//   omega_out_packed out  applied omega, same packing as target_packed
//   omega_valid      out  high once the initial snap has happened
//   settled          out  high when every applied omega equals its target
//   step_pulse       out  one-clk pulse after a scan that changed something
//   scan_idx         out  harmonic being processed in SCAN, 0 otherwise
// ---------------------------------------------------------------------------
module sr_omega_slewer #(
    parameter int WIDTH         = 18,
    parameter int NUM_HARMONICS = 5,
    parameter int SLEW_DIV      = 16,
    parameter int MAX_STEP      = 1,
    parameter int SNAP_THRESH   = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic [NUM_HARMONICS*WIDTH-1:0] target_packed,
    input  logic                           hold,
    output logic [NUM_HARMONICS*WIDTH-1:0] omega_out_packed,
    output logic                           omega_valid,
    output logic                           settled,
    output logic                           step_pulse,
    output logic [2:0]                     scan_idx
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT,
        ST_SCAN
    } state_t;

    // |target - applied| never exceeds 2^WIDTH - 1, so limits are clamped to
    // 2^WIDTH and then fit the WIDTH+1 bit unsigned magnitude.
    localparam int MAG_MAX    = 1 << WIDTH;
    localparam int STEP_CLAMP = (MAX_STEP > MAG_MAX) ? MAG_MAX : MAX_STEP;
    localparam int SNAP_CLAMP = (SNAP_THRESH > MAG_MAX) ? MAG_MAX :
                                (SNAP_THRESH < 0) ? 0 : SNAP_THRESH;
    localparam logic [WIDTH:0] STEP_LIM = (WIDTH+1)'(STEP_CLAMP);
    localparam logic [WIDTH:0] SNAP_LIM = (WIDTH+1)'(SNAP_CLAMP);
    localparam logic [15:0]    DIV_LAST = 16'(SLEW_DIV - 1);
    localparam logic [2:0]     LAST_IDX = 3'(NUM_HARMONICS - 1);

`ifdef SR_SLEW_SNAP_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    // Clamp a WIDTH+2 bit signed value into the signed WIDTH-bit range.
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH+1:0] x);
        logic signed [WIDTH+1:0] hi;
        logic signed [WIDTH+1:0] lo;
        hi = {3'b000, {(WIDTH-1){1'b1}}};
        lo = {3'b111, {(WIDTH-1){1'b0}}};
        if (x > hi) begin
            return hi[WIDTH-1:0];
        end else if (x < lo) begin
            return lo[WIDTH-1:0];
        end
        return x[WIDTH-1:0];
    endfunction

    // One slew decision for a single harmonic. Reaching the target whenever
    // the remaining distance is within one step is what prevents overshoot.
    function automatic logic signed [WIDTH-1:0] slew_step(
        input logic signed [WIDTH-1:0] cur,
        input logic signed [WIDTH-1:0] tgt
    );
        logic signed [WIDTH:0]   d;
        logic        [WIDTH:0]   mag;
        logic signed [WIDTH+1:0] moved;
        d   = $signed({tgt[WIDTH-1], tgt}) - $signed({cur[WIDTH-1], cur});
        mag = d[WIDTH] ? $unsigned(-d) : $unsigned(d);
        if ((SNAP_EN && (mag > SNAP_LIM)) || (mag <= STEP_LIM)) begin
            return tgt;
        end
        if (d[WIDTH]) begin
            moved = $signed({cur[WIDTH-1], cur[WIDTH-1], cur}) - $signed({1'b0, STEP_LIM});
        end else begin
            moved = $signed({cur[WIDTH-1], cur[WIDTH-1], cur}) + $signed({1'b0, STEP_LIM});
        end
        return sat_w(moved);
    endfunction

    state_t                  state_q, state_d;
    logic [15:0]             div_q, div_d;
    logic signed [WIDTH-1:0] omega_q [NUM_HARMONICS];
    logic signed [WIDTH-1:0] omega_d [NUM_HARMONICS];
    logic                    valid_q, valid_d;
    logic                    settled_q, settled_d;
    logic                    step_pulse_q, step_pulse_d;
    logic [2:0]              scan_idx_q, scan_idx_d;
    logic                    changed_q, changed_d;

    logic signed [WIDTH-1:0] tgt [NUM_HARMONICS];
    logic signed [WIDTH-1:0] next_val;
    logic                    hit;
    logic                    all_eq;

    always_comb begin
        for (int k = 0; k < NUM_HARMONICS; k++) begin
            tgt[k] = target_packed[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        omega_d      = omega_q;
        valid_d      = valid_q;
        step_pulse_d = 1'b0;
        scan_idx_d   = scan_idx_q;
        changed_d    = changed_q;
        next_val     = '0;
        hit          = 1'b0;
        all_eq       = 1'b1;

        for (int k = 0; k < NUM_HARMONICS; k++) begin
            if (omega_q[k] != tgt[k]) begin
                all_eq = 1'b0;
            end
        end
        settled_d = (state_q != ST_INIT) && all_eq;

        case (state_q)
            ST_INIT: begin
                if (clk_en) begin
                    for (int k = 0; k < NUM_HARMONICS; k++) begin
                        omega_d[k] = tgt[k];
                    end
                    valid_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // hold freezes the count without clearing it.
                if (clk_en && !hold) begin
                    if (div_q == DIV_LAST) begin
                        div_d      = '0;
                        state_d    = ST_SCAN;
                        scan_idx_d = '0;
                        changed_d  = 1'b0;
                    end else begin
                        div_d = div_q + 16'd1;
                    end
                end
            end
            ST_SCAN: begin
                // clk_en and hold are ignored here; the scan always completes.
                next_val             = slew_step(omega_q[scan_idx_q], tgt[scan_idx_q]);
                hit                  = (next_val != omega_q[scan_idx_q]);
                omega_d[scan_idx_q]  = next_val;
                changed_d            = changed_q | hit;
                if (scan_idx_q == LAST_IDX) begin
                    state_d      = ST_WAIT;
                    scan_idx_d   = '0;
                    step_pulse_d = changed_q | hit;
                end else begin
                    scan_idx_d = scan_idx_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            div_q        <= '0;
            valid_q      <= 1'b0;
            settled_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            scan_idx_q   <= '0;
            changed_q    <= 1'b0;
            for (int k = 0; k < NUM_HARMONICS; k++) begin
                omega_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            valid_q      <= valid_d;
            settled_q    <= settled_d;
            step_pulse_q <= step_pulse_d;
            scan_idx_q   <= scan_idx_d;
            changed_q    <= changed_d;
            for (int k = 0; k < NUM_HARMONICS; k++) begin
                omega_q[k] <= omega_d[k];
            end
        end
    end

    always_comb begin
        omega_out_packed = '0;
        for (int k = 0; k < NUM_HARMONICS; k++) begin
            omega_out_packed[k*WIDTH +: WIDTH] = omega_q[k];
        end
    end

    assign omega_valid = valid_q;
    assign settled     = settled_q;
    assign step_pulse  = step_pulse_q;
    assign scan_idx    = scan_idx_q;

endmodule

// File: tb/tb_sr_omega_slewer.sv
// ---------------------------------------------------------------------------
// tb_sr_omega_slewer
//
// Randomized bench for sr_omega_slewer with a scoreboard. The stimulus side
// keeps a behavioural model of the slew rules (tick counting, per-harmonic
// integer stepping) and pushes the expected snap vector and every expected
// step result (with the clk_en tick it belongs to) into queues. A monitor
// pops and compares whenever the DUT raises omega_valid or step_pulse.
// ---------------------------------------------------------------------------
module tb_sr_omega_slewer;

    localparam int W    = 18;
    localparam int N    = 5;
    localparam int DIV  = 16;
    localparam int STEP = 2;
    localparam int SNAP = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clk_en;
    logic           hold;
    logic [N*W-1:0] target_packed;
    logic [N*W-1:0] omega_out_packed;
    logic           omega_valid;
    logic           settled;
    logic           step_pulse;
    logic [2:0]     scan_idx;

    always #5 clk = ~clk;

    sr_omega_slewer #(
        .WIDTH(W), .NUM_HARMONICS(N), .SLEW_DIV(DIV),
        .MAX_STEP(STEP), .SNAP_THRESH(SNAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .target_packed(target_packed), .hold(hold),
        .omega_out_packed(omega_out_packed), .omega_valid(omega_valid),
        .settled(settled), .step_pulse(step_pulse), .scan_idx(scan_idx)
    );

    typedef struct {
        int             tick;
        logic [N*W-1:0] vec;
    } exp_t;

    exp_t           step_q[$];
    logic [N*W-1:0] snap_q[$];
    int             total = 0;
    int             bad   = 0;
    int             tick_cnt = 0;

    int m_tgt[N];
    int m_app[N];
    bit m_init;
    int m_div;

    task automatic check_int(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack_app();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(m_app[k]);
        return r;
    endfunction

    // Slew rule in plain integer arithmetic.
    function automatic int model_step(input int app, input int tgt);
        int d;
        int mag;
        d   = tgt - app;
        mag = (d < 0) ? -d : d;
`ifdef SR_SLEW_SNAP_EN
        if (mag > SNAP) return tgt;
`endif
        if (mag <= STEP) return tgt;
        return (d > 0) ? app + STEP : app - STEP;
    endfunction

    function automatic bit exp_settled();
        if (m_init) return 1'b0;
        for (int k = 0; k < N; k++) if (m_app[k] != m_tgt[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_tgt(input int k, input int v);
        m_tgt[k] = v;
        target_packed[k*W +: W] = W'(v);
    endtask

    // Wait long enough that any scan started by the previous tick is over.
    task automatic quiet();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_tick(input bit h, input bit chk_idx, output bit ended);
        bit any;
        int nv;
        repeat ($urandom_range(7, 11)) @(negedge clk);
        check_int("settled", settled, exp_settled());
        check_int("omega_valid", omega_valid, !m_init);
        clk_en = 1'b1;
        hold   = h;
        tick_cnt++;
        ended  = 1'b0;
        if (m_init) begin
            for (int k = 0; k < N; k++) m_app[k] = m_tgt[k];
            m_init = 1'b0;
            snap_q.push_back(pack_app());
        end else if (!h) begin
            m_div++;
            if (m_div == DIV) begin
                m_div = 0;
                ended = 1'b1;
                any   = 1'b0;
                for (int k = 0; k < N; k++) begin
                    nv = model_step(m_app[k], m_tgt[k]);
                    if (nv != m_app[k]) any = 1'b1;
                    m_app[k] = nv;
                end
                if (any) step_q.push_back('{tick: tick_cnt, vec: pack_app()});
            end
        end
        @(negedge clk);
        clk_en = 1'b0;
        hold   = 1'b0;
        if (ended && chk_idx) begin
            for (int k = 1; k < N; k++) begin
                @(negedge clk);
                check_int("scan_idx", scan_idx, k);
            end
        end
    endtask

    task automatic run_periods(input int p, input int hold_pct);
        int n;
        bit e;
        bit h;
        n = 0;
        while (n < p) begin
            h = ($urandom_range(0, 99) < hold_pct);
            do_tick(h, 1'b1, e);
            if (e) n++;
        end
    endtask

    task automatic run_ticks(input int t, input bit h);
        bit e;
        for (int i = 0; i < t; i++) do_tick(h, 1'b1, e);
    endtask

    // Monitor: compares whenever the DUT presents a snap or a step result.
    bit   valid_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
        end else begin
            if (omega_valid && !valid_prev) begin
                check_int("snap_pending", snap_q.size() > 0, 1);
                if (snap_q.size() > 0) check_vec("snap_vals", omega_out_packed, snap_q.pop_front());
                check_int("snap_no_pulse", step_pulse, 0);
            end
            valid_prev = omega_valid;
            if (step_pulse) begin
                check_int("step_pending", step_q.size() > 0, 1);
                if (step_q.size() > 0) begin
                    mon_e = step_q.pop_front();
                    check_int("step_tick", tick_cnt, mon_e.tick);
                    check_vec("step_vals", omega_out_packed, mon_e.vec);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        bit found;
        int v;
        int kind;

        rst_n = 1'b0; clk_en = 1'b0; hold = 1'b0; target_packed = '0;
        m_init = 1'b1; m_div = 0;
        for (int k = 0; k < N; k++) begin m_tgt[k] = 0; m_app[k] = 0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("reset_omega", omega_out_packed, '0);
        check_int("reset_valid", omega_valid, 0);
        check_int("reset_settled", settled, 0);
        check_int("reset_step", step_pulse, 0);
        check_int("reset_idx", scan_idx, 0);

        // Initial snap to the nominal harmonic set.
        set_tgt(0, 823); set_tgt(1, 643); set_tgt(2, 514); set_tgt(3, 354); set_tgt(4, 196);
        do_tick(1'b0, 1'b1, e);
        run_periods(2, 0);

        // Small step on harmonic 4: 196 -> 199.
        quiet(); set_tgt(4, 199);
        run_periods(3, 0);

        // hold in mid-divider: count freezes, then continues.
        quiet(); set_tgt(1, 651);
        run_ticks(5, 1'b0);
        run_ticks(40, 1'b1);
        run_periods(5, 0);

        // Long descent with an odd remainder: 823 -> 700.
        quiet(); set_tgt(0, 700);
        run_periods(63, 0);

        // Large and small jumps (snap behaviour depends on the build).
        quiet(); set_tgt(3, m_tgt[3] + 100); set_tgt(2, m_tgt[2] + 10);
        run_periods(6, 0);

        // Randomized target moves with occasional hold.
        for (int r = 0; r < 12; r++) begin
            quiet();
            for (int k = 0; k < N; k++) begin
                kind = $urandom_range(0, 7);
                if (kind == 0)      v = ($urandom_range(0, 1) != 0) ? 100 : -100;
                else if (kind == 1) v = ($urandom_range(0, 1) != 0) ? 10 : -10;
                else                v = $urandom_range(0, 10) - 5;
                set_tgt(k, m_tgt[k] + v);
            end
            run_periods(6, 12);
        end

        // Reset in the middle of a scan.
        quiet(); set_tgt(2, m_tgt[2] + 30);
        e = 1'b0;
        while (!e) do_tick(1'b0, 1'b0, e);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (scan_idx == 3'd2) found = 1'b1;
        end
        check_int("reach_idx2", found, 1);
        rst_n = 1'b0;
        step_q.delete();
        @(negedge clk);
        check_vec("midscan_rst_omega", omega_out_packed, '0);
        check_int("midscan_rst_valid", omega_valid, 0);
        check_int("midscan_rst_settled", settled, 0);
        check_int("midscan_rst_step", step_pulse, 0);
        check_int("midscan_rst_idx", scan_idx, 0);
        rst_n = 1'b1;
        m_init = 1'b1; m_div = 0;
        set_tgt(2, m_tgt[2] - 7);
        do_tick(1'b0, 1'b1, e);
        run_periods(3, 10);

        quiet(); quiet();
        check_int("step_queue_empty", step_q.size(), 0);
        check_int("snap_queue_empty", snap_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
